// File: rtl/seq_detector_param_if.sv
// Bus for the serial pattern detector: qualified serial input and controls
// toward the detector, registered match status back from it.
interface seq_detector_param_if #(
    parameter int ST_W  = 2,
    parameter int CNT_W = 8
);
    logic             din_valid;
    logic             din;
    logic             overlap_en;
    logic             clear;
    logic             match;
    logic [ST_W-1:0]  state_o;
    logic [CNT_W-1:0] match_cnt;
    logic             cnt_sat;

    modport master (
        output din_valid, din, overlap_en, clear,
        input  match, state_o, match_cnt, cnt_sat
    );

    modport slave (
        input  din_valid, din, overlap_en, clear,
        output match, state_o, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_detector_param.sv
// Parametrised serial pattern detector with an elaboration-time KMP fallback
// table, runtime overlap mode and a saturating match counter.
module seq_detector_param #(
    parameter int                 PAT_LEN = 4,
    parameter logic [PAT_LEN-1:0] PATTERN = 4'b1011,
    parameter int                 CNT_W   = 8,
    parameter int                 ST_W    = $clog2(PAT_LEN)
) (
    input  logic                clk,
    input  logic                rst,
    seq_detector_param_if.slave bus
);

    // Table is indexed by {state, bit}; unreachable state codes fall back to S_0.
    localparam int               TBL_N    = 2 << ST_W;
    localparam logic [ST_W-1:0]  LAST_ST  = ST_W'(PAT_LEN - 1);
    localparam logic             LAST_BIT = PATTERN[0];

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_pat_len
        $error("seq_detector_param: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("seq_detector_param: CNT_W must be at least 1");
    end

    // Longest suffix of (prefix_k, b) that is a pattern prefix, capped below PAT_LEN.
    function automatic logic [TBL_N*ST_W-1:0] build_next_tbl();
        logic [TBL_N*ST_W-1:0] tbl;
        logic [PAT_LEN-1:0]    seq;
        int                    best;
        logic                  hit;
        tbl = '0;
        for (int k = 0; k < PAT_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                seq = '0;
                for (int j = 0; j < k; j++) begin
                    seq[j] = PATTERN[PAT_LEN-1-j];
                end
                seq[k] = b[0];
                best = 0;
                for (int len = 1; (len <= k + 1) && (len < PAT_LEN); len++) begin
                    hit = 1'b1;
                    for (int m = 0; m < len; m++) begin
                        if (seq[k+1-len+m] != PATTERN[PAT_LEN-1-m]) begin
                            hit = 1'b0;
                        end
                    end
                    if (hit) begin
                        best = len;
                    end
                end
                tbl[(2*k+b)*ST_W +: ST_W] = best[ST_W-1:0];
            end
        end
        return tbl;
    endfunction

    localparam logic [TBL_N*ST_W-1:0] NEXT_TBL = build_next_tbl();

    logic [ST_W-1:0]  state_q, state_d;
    logic             match_q, match_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             sat_q,   sat_d;
    logic [ST_W:0]    idx_s;
    logic [ST_W-1:0]  nxt_s;
    logic             hit_s;

    // Next-state, match pulse and counter update for one clock.
    always_comb begin
        idx_s   = {state_q, bus.din};
        nxt_s   = NEXT_TBL[int'(idx_s)*ST_W +: ST_W];
        hit_s   = (state_q == LAST_ST) && (bus.din == LAST_BIT);
        state_d = state_q;
        match_d = 1'b0;
        cnt_d   = cnt_q;
        if (bus.clear) begin
            state_d = '0;
            cnt_d   = '0;
        end else if (bus.din_valid) begin
            if (hit_s) begin
                match_d = 1'b1;
                state_d = bus.overlap_en ? nxt_s : '0;
                cnt_d   = sat_q ? cnt_q : cnt_q + CNT_W'(1);
            end else begin
                state_d = nxt_s;
            end
        end else begin
            state_d = state_q;
        end
        sat_d = &cnt_d;
    end

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            match_q <= 1'b0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.state_o   = state_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench: two detectors (8-bit and 2-bit counters) share one
// stimulus stream and are compared with a history-based reference model.
module tb_seq_detector_param;

    localparam int PL = 4;

    logic clk;
    logic rst;
    logic din_valid, din, overlap_en, clear;

    int n_checks;
    int n_errors;

    logic [PL-1:0] pat_v;
    bit            hist[$];
    bit            m_match;
    int            m_cnt8;
    int            m_cnt2;

    seq_detector_param_if #(.ST_W(2), .CNT_W(8)) bus8 ();
    seq_detector_param_if #(.ST_W(2), .CNT_W(2)) bus2 ();

    assign bus8.din_valid  = din_valid;
    assign bus8.din        = din;
    assign bus8.overlap_en = overlap_en;
    assign bus8.clear      = clear;
    assign bus2.din_valid  = din_valid;
    assign bus2.din        = din;
    assign bus2.overlap_en = overlap_en;
    assign bus2.clear      = clear;

    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(8)) dut8 (
        .clk(clk), .rst(rst), .bus(bus8.slave)
    );
    seq_detector_param #(.PAT_LEN(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .bus(bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: longest suffix of the accepted history that is a proper pattern prefix.
    function automatic int model_state();
        int  n;
        bit  ok;
        n = hist.size();
        for (int len = PL - 1; len > 0; len--) begin
            if (len <= n) begin
                ok = 1'b1;
                for (int m = 0; m < len; m++) begin
                    if (hist[n-len+m] != pat_v[PL-1-m]) ok = 1'b0;
                end
                if (ok) return len;
            end
        end
        return 0;
    endfunction

    function automatic bit model_full_match();
        int n;
        n = hist.size();
        if (n < PL) return 1'b0;
        for (int m = 0; m < PL; m++) begin
            if (hist[n-PL+m] != pat_v[PL-1-m]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        hist.delete();
        m_match = 1'b0;
        m_cnt8  = 0;
        m_cnt2  = 0;
    endtask

    // Drive one cycle of inputs, advance the model, and land #1 after the edge.
    task automatic step(input bit v, input bit b, input bit ov, input bit clr);
        din_valid  = v;
        din        = b;
        overlap_en = ov;
        clear      = clr;
        m_match    = 1'b0;
        if (clr) begin
            hist.delete();
            m_cnt8 = 0;
            m_cnt2 = 0;
        end else if (v) begin
            hist.push_back(b);
            if (hist.size() > PL) void'(hist.pop_front());
            if (model_full_match()) begin
                m_match = 1'b1;
                if (m_cnt8 < 255) m_cnt8++;
                if (m_cnt2 < 3) m_cnt2++;
                if (!ov) hist.delete();
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus8.state_o !== 2'd0) begin n_errors++; $display("FAIL reset_state: got %0d expected 0", bus8.state_o); end
        n_checks++; if (bus8.match !== 1'b0) begin n_errors++; $display("FAIL reset_match: got %b expected 0", bus8.match); end
        n_checks++; if (bus8.match_cnt !== 8'd0) begin n_errors++; $display("FAIL reset_cnt: got %0d expected 0", bus8.match_cnt); end
        n_checks++; if (bus2.cnt_sat !== 1'b0) begin n_errors++; $display("FAIL reset_sat: got %b expected 0", bus2.cnt_sat); end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_overlap();
        logic [6:0] bits;
        int em[7] = '{0, 0, 0, 1, 0, 0, 1};
        int es[7] = '{1, 2, 3, 1, 2, 3, 1};
        bits = 7'b1011011;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, bits[6-i], 1'b1, 1'b0);
            n_checks++; if (bus8.match !== 1'(em[i])) begin n_errors++; $display("FAIL overlap_match[%0d]: got %b expected %0d", i, bus8.match, em[i]); end
            n_checks++; if (bus8.state_o !== 2'(es[i])) begin n_errors++; $display("FAIL overlap_state[%0d]: got %0d expected %0d", i, bus8.state_o, es[i]); end
        end
        n_checks++; if (bus8.match_cnt !== 8'd2) begin n_errors++; $display("FAIL overlap_cnt: got %0d expected 2", bus8.match_cnt); end
    endtask

    task automatic test_non_overlap();
        logic [9:0] bits;
        int em[10] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        int es[10] = '{1, 2, 3, 0, 0, 1, 1, 2, 3, 0};
        bits = 10'b1011011011;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            step(1'b1, bits[9-i], 1'b0, 1'b0);
            n_checks++; if (bus8.match !== 1'(em[i])) begin n_errors++; $display("FAIL nonovl_match[%0d]: got %b expected %0d", i, bus8.match, em[i]); end
            n_checks++; if (bus8.state_o !== 2'(es[i])) begin n_errors++; $display("FAIL nonovl_state[%0d]: got %0d expected %0d", i, bus8.state_o, es[i]); end
            if (i == 6) begin
                n_checks++; if (bus8.match_cnt !== 8'd1) begin n_errors++; $display("FAIL nonovl_cnt1: got %0d expected 1", bus8.match_cnt); end
            end
        end
        n_checks++; if (bus8.match_cnt !== 8'd2) begin n_errors++; $display("FAIL nonovl_cnt2: got %0d expected 2", bus8.match_cnt); end
    endtask

    task automatic test_fallback();
        logic [4:0] bits;
        int em[5] = '{0, 0, 0, 0, 1};
        int es[5] = '{1, 1, 2, 3, 1};
        bits = 5'b11011;
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, bits[4-i], 1'b1, 1'b0);
            n_checks++; if (bus8.match !== 1'(em[i])) begin n_errors++; $display("FAIL fallback_match[%0d]: got %b expected %0d", i, bus8.match, em[i]); end
            n_checks++; if (bus8.state_o !== 2'(es[i])) begin n_errors++; $display("FAIL fallback_state[%0d]: got %0d expected %0d", i, bus8.state_o, es[i]); end
        end
        n_checks++; if (bus8.match_cnt !== 8'd1) begin n_errors++; $display("FAIL fallback_cnt: got %0d expected 1", bus8.match_cnt); end
    endtask

    task automatic test_valid_gaps();
        int es[4] = '{1, 2, 3, 1};
        step(1'b0, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, pat_v[3-i], 1'b1, 1'b0);
            n_checks++; if (bus8.match !== 1'(i == 3)) begin n_errors++; $display("FAIL gaps_match_bit[%0d]: got %b expected %0d", i, bus8.match, (i == 3)); end
            n_checks++; if (bus8.state_o !== 2'(es[i])) begin n_errors++; $display("FAIL gaps_state_bit[%0d]: got %0d expected %0d", i, bus8.state_o, es[i]); end
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    step(1'b0, 1'(g == 0), 1'b1, 1'b0);
                    n_checks++; if (bus8.match !== 1'b0) begin n_errors++; $display("FAIL gaps_match_idle[%0d]: got %b expected 0", i, bus8.match); end
                    n_checks++; if (bus8.state_o !== 2'(es[i])) begin n_errors++; $display("FAIL gaps_state_idle[%0d]: got %0d expected %0d", i, bus8.state_o, es[i]); end
                end
            end
        end
        n_checks++; if (bus8.match_cnt !== 8'd1) begin n_errors++; $display("FAIL gaps_cnt: got %0d expected 1", bus8.match_cnt); end
    endtask

    task automatic test_reset_mid_pattern();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, pat_v[3-i], 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b1, pat_v[3-i], 1'b0, 1'b0);
        n_checks++; if (bus8.state_o !== 2'd3) begin n_errors++; $display("FAIL midrst_pre_state: got %0d expected 3", bus8.state_o); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (bus8.state_o !== 2'd0) begin n_errors++; $display("FAIL midrst_state: got %0d expected 0", bus8.state_o); end
        n_checks++; if (bus8.match !== 1'b0) begin n_errors++; $display("FAIL midrst_match: got %b expected 0", bus8.match); end
        n_checks++; if (bus8.match_cnt !== 8'd0) begin n_errors++; $display("FAIL midrst_cnt: got %0d expected 0", bus8.match_cnt); end
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_saturation_clear();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) step(1'b1, pat_v[3-i], 1'b0, 1'b0);
            n_checks++; if (bus2.match !== 1'b1) begin n_errors++; $display("FAIL sat_match[%0d]: got %b expected 1", r, bus2.match); end
            n_checks++; if (bus2.match_cnt !== 2'((r < 2) ? r + 1 : 3)) begin n_errors++; $display("FAIL sat_cnt2[%0d]: got %0d expected %0d", r, bus2.match_cnt, (r < 2) ? r + 1 : 3); end
            n_checks++; if (bus2.cnt_sat !== 1'(r >= 2)) begin n_errors++; $display("FAIL sat_flag2[%0d]: got %b expected %0d", r, bus2.cnt_sat, (r >= 2)); end
            n_checks++; if (bus8.match_cnt !== 8'(r + 1)) begin n_errors++; $display("FAIL sat_cnt8[%0d]: got %0d expected %0d", r, bus8.match_cnt, r + 1); end
        end
        for (int i = 0; i < 3; i++) step(1'b1, pat_v[3-i], 1'b0, 1'b0);
        step(1'b1, pat_v[0], 1'b0, 1'b1);
        n_checks++; if (bus2.match !== 1'b0) begin n_errors++; $display("FAIL clr_match: got %b expected 0", bus2.match); end
        n_checks++; if (bus2.match_cnt !== 2'd0) begin n_errors++; $display("FAIL clr_cnt2: got %0d expected 0", bus2.match_cnt); end
        n_checks++; if (bus2.cnt_sat !== 1'b0) begin n_errors++; $display("FAIL clr_sat2: got %b expected 0", bus2.cnt_sat); end
        n_checks++; if (bus2.state_o !== 2'd0) begin n_errors++; $display("FAIL clr_state: got %0d expected 0", bus2.state_o); end
        n_checks++; if (bus8.match_cnt !== 8'd0) begin n_errors++; $display("FAIL clr_cnt8: got %0d expected 0", bus8.match_cnt); end
    endtask

    task automatic test_random();
        bit v, b, ov, clr;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        for (int c = 0; c < 800; c++) begin
            v   = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom_range(0, 1));
            ov  = 1'($urandom_range(0, 1));
            clr = ($urandom_range(0, 59) == 0);
            step(v, b, ov, clr);
            n_checks++; if (bus8.match !== m_match) begin n_errors++; $display("FAIL rand_match[%0d]: got %b expected %b", c, bus8.match, m_match); end
            n_checks++; if (bus8.state_o !== 2'(model_state())) begin n_errors++; $display("FAIL rand_state[%0d]: got %0d expected %0d", c, bus8.state_o, model_state()); end
            n_checks++; if (bus8.match_cnt !== 8'(m_cnt8)) begin n_errors++; $display("FAIL rand_cnt8[%0d]: got %0d expected %0d", c, bus8.match_cnt, m_cnt8); end
            n_checks++; if (bus8.cnt_sat !== 1'(m_cnt8 == 255)) begin n_errors++; $display("FAIL rand_sat8[%0d]: got %b expected %0d", c, bus8.cnt_sat, (m_cnt8 == 255)); end
            n_checks++; if (bus2.match_cnt !== 2'(m_cnt2)) begin n_errors++; $display("FAIL rand_cnt2[%0d]: got %0d expected %0d", c, bus2.match_cnt, m_cnt2); end
            n_checks++; if (bus2.cnt_sat !== 1'(m_cnt2 == 3)) begin n_errors++; $display("FAIL rand_sat2[%0d]: got %b expected %0d", c, bus2.cnt_sat, (m_cnt2 == 3)); end
        end
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        pat_v      = 4'b1011;
        rst        = 1'b1;
        din_valid  = 1'b0;
        din        = 1'b0;
        overlap_en = 1'b0;
        clear      = 1'b0;
        model_reset();
        test_reset();
        test_overlap();
        test_non_overlap();
        test_fallback();
        test_valid_gaps();
        test_reset_mid_pattern();
        test_saturation_clear();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
